// File: rtl/alu_multicycle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_multicycle                                                             |
// | Execute-stage ALU: registered results, multi-cycle multiplier, flush.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_multicycle #(
  parameter int DATA_W      = 32,
  parameter int OPC_W       = 8,
  parameter int MUL_LATENCY = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OPC_W-1:0]  req_opcode,
  input  logic [DATA_W-1:0] req_val1,
  input  logic [DATA_W-1:0] req_val2,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_ovf,
  output logic              rsp_illegal
);

  localparam logic [0:0] c_idle     = 1'b0;
  localparam logic [0:0] c_mul_busy = 1'b1;

  localparam bit         c_multi    = (MUL_LATENCY > 1);
  localparam logic [3:0] c_mul_init = 4'(MUL_LATENCY - 1);

  localparam logic [OPC_W-1:0] c_op_add  = OPC_W'(8'h00);
  localparam logic [OPC_W-1:0] c_op_sub  = OPC_W'(8'h01);
  localparam logic [OPC_W-1:0] c_op_mul  = OPC_W'(8'h02);
  localparam logic [OPC_W-1:0] c_op_ldb  = OPC_W'(8'h10);
  localparam logic [OPC_W-1:0] c_op_ldw  = OPC_W'(8'h11);
  localparam logic [OPC_W-1:0] c_op_stb  = OPC_W'(8'h12);
  localparam logic [OPC_W-1:0] c_op_stw  = OPC_W'(8'h13);
  localparam logic [OPC_W-1:0] c_op_beq  = OPC_W'(8'h30);
  localparam logic [OPC_W-1:0] c_op_jump = OPC_W'(8'h31);
  localparam logic [OPC_W-1:0] c_op_tlbw = OPC_W'(8'h32);
  localparam logic [OPC_W-1:0] c_op_iret = OPC_W'(8'h33);

  logic [0:0]        r_state;
  logic [0:0]        w_state_next;
  logic [3:0]        r_count;
  logic [3:0]        w_count_next;
  logic [DATA_W-1:0] r_mul_a;
  logic [DATA_W-1:0] r_mul_b;

  logic              w_accept;
  logic              w_start_mul;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_mul_a;
  logic [DATA_W-1:0] w_mul_b;
  logic [DATA_W-1:0] w_product;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_ovf;
  logic              w_alu_illegal;

  assign w_accept    = req_valid && req_ready;
  assign w_start_mul = w_accept && (req_opcode == c_op_mul) && c_multi;
  assign w_mul_done  = (r_state == c_mul_busy) && (r_count == 4'd1) && !flush;

  // A single multiplier: fed from captured operands when multi-cycle, else directly.
  assign w_mul_a   = c_multi ? r_mul_a : req_val1;
  assign w_mul_b   = c_multi ? r_mul_b : req_val2;
  assign w_product = w_mul_a * w_mul_b;
  assign w_sum     = req_val1 + req_val2;
  assign w_diff    = req_val1 - req_val2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_idle;
      r_count <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    if (flush) begin
      w_state_next = c_idle;
      w_count_next = 4'd0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_start_mul) begin
            w_state_next = c_mul_busy;
            w_count_next = c_mul_init;
          end
        end
        c_mul_busy: begin
          if (r_count == 4'd1) begin
            w_state_next = c_idle;
            w_count_next = 4'd0;
          end else begin
            w_count_next = r_count - 4'd1;
          end
        end
        default: begin
          w_state_next = c_idle;
          w_count_next = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    req_ready = (r_state == c_idle) && !flush && !reset;
  end

  always_comb begin
    w_alu_result  = '0;
    w_alu_ovf     = 1'b0;
    w_alu_illegal = 1'b0;
    case (req_opcode)
      c_op_add: begin
        w_alu_result = w_sum;
        w_alu_ovf    = (req_val1[DATA_W-1] == req_val2[DATA_W-1]) &&
                       (w_sum[DATA_W-1] != req_val1[DATA_W-1]);
      end
      c_op_sub: begin
        w_alu_result = w_diff;
        w_alu_ovf    = (req_val1[DATA_W-1] != req_val2[DATA_W-1]) &&
                       (w_diff[DATA_W-1] != req_val1[DATA_W-1]);
      end
      c_op_mul:                                       w_alu_result = w_product;
      c_op_ldb, c_op_ldw, c_op_stb, c_op_stw, c_op_jump: w_alu_result = w_sum;
      c_op_beq:                                       w_alu_result = DATA_W'(req_val1 == req_val2);
      c_op_tlbw, c_op_iret:                           w_alu_result = '0;
      default:                                        w_alu_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_ovf     <= 1'b0;
      rsp_illegal <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else begin
      if (w_start_mul) begin
        r_mul_a <= req_val1;
        r_mul_b <= req_val2;
      end
      // Flush leaves the last result and flags visible; only the pulse is killed.
      if (flush) begin
        rsp_valid <= 1'b0;
      end else if (w_mul_done) begin
        rsp_valid   <= 1'b1;
        rsp_result  <= w_product;
        rsp_zero    <= (w_product == '0);
        rsp_ovf     <= 1'b0;
        rsp_illegal <= 1'b0;
      end else if (w_accept && !w_start_mul) begin
        rsp_valid   <= 1'b1;
        rsp_result  <= w_alu_result;
        rsp_zero    <= (w_alu_result == '0);
        rsp_ovf     <= w_alu_ovf;
        rsp_illegal <= w_alu_illegal;
      end else begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_multicycle                                                          |
// | Directed bench with a reference model for alu_multicycle.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_multicycle;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        no_flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_opcode = 8'h00;
  logic [31:0] req_val1 = 32'h0;
  logic [31:0] req_val2 = 32'h0;
  logic        req_ready, rsp_valid, rsp_zero, rsp_ovf, rsp_illegal;
  logic [31:0] rsp_result;

  logic        l1_valid = 1'b0, l15_valid = 1'b0, w16_valid = 1'b0;
  logic [7:0]  l1_op = 8'h00, l15_op = 8'h00, w16_op = 8'h00;
  logic [31:0] l1_a = 32'h0, l1_b = 32'h0, l15_a = 32'h0, l15_b = 32'h0;
  logic [15:0] w16_a = 16'h0, w16_b = 16'h0;
  logic        l1_ready, l1_rvalid, l1_zero, l1_ovf, l1_ill;
  logic        l15_ready, l15_rvalid, l15_zero, l15_ovf, l15_ill;
  logic        w16_ready, w16_rvalid, w16_zero, w16_ovf, w16_ill;
  logic [31:0] l1_res, l15_res;
  logic [15:0] w16_res;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.DATA_W(32), .OPC_W(8), .MUL_LATENCY(LAT)) dut (
    .clock(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_val1(req_val1), .req_val2(req_val2), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_illegal(rsp_illegal));

  alu_multicycle #(.DATA_W(32), .OPC_W(8), .MUL_LATENCY(1)) dut_l1 (
    .clock(clk), .reset(reset), .flush(no_flush), .req_valid(l1_valid), .req_ready(l1_ready),
    .req_opcode(l1_op), .req_val1(l1_a), .req_val2(l1_b), .rsp_valid(l1_rvalid),
    .rsp_result(l1_res), .rsp_zero(l1_zero), .rsp_ovf(l1_ovf), .rsp_illegal(l1_ill));

  alu_multicycle #(.DATA_W(32), .OPC_W(8), .MUL_LATENCY(15)) dut_l15 (
    .clock(clk), .reset(reset), .flush(no_flush), .req_valid(l15_valid), .req_ready(l15_ready),
    .req_opcode(l15_op), .req_val1(l15_a), .req_val2(l15_b), .rsp_valid(l15_rvalid),
    .rsp_result(l15_res), .rsp_zero(l15_zero), .rsp_ovf(l15_ovf), .rsp_illegal(l15_ill));

  alu_multicycle #(.DATA_W(16), .OPC_W(8), .MUL_LATENCY(3)) dut_w16 (
    .clock(clk), .reset(reset), .flush(no_flush), .req_valid(w16_valid), .req_ready(w16_ready),
    .req_opcode(w16_op), .req_val1(w16_a), .req_val2(w16_b), .rsp_valid(w16_rvalid),
    .rsp_result(w16_res), .rsp_zero(w16_zero), .rsp_ovf(w16_ovf), .rsp_illegal(w16_ill));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (main DUT) ----------------
  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        ill;
  } ref_t;

  localparam longint LMAX = 64'sd2147483647;
  localparam longint LMIN = -64'sd2147483648;

  function automatic ref_t ref_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    ref_t        r;
    longint      s;
    logic [63:0] p;
    r = '{res: 32'h0, ovf: 1'b0, ill: 1'b0};
    case (op)
      8'h00: begin
        s = longint'($signed(a)) + longint'($signed(b));
        r.res = 32'(s);
        r.ovf = (s > LMAX) || (s < LMIN);
      end
      8'h01: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r.res = 32'(s);
        r.ovf = (s > LMAX) || (s < LMIN);
      end
      8'h02: begin
        p = {32'h0, a} * {32'h0, b};
        r.res = p[31:0];
      end
      8'h10, 8'h11, 8'h12, 8'h13, 8'h31: r.res = a + b;
      8'h30: r.res = (a == b) ? 32'd1 : 32'd0;
      8'h32, 8'h33: r.res = 32'h0;
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  ref_t        w_ref;
  longint      cyc   = 0;
  longint      m_due = -1;
  logic        m_valid = 1'b0, m_zero = 1'b0, m_ovf = 1'b0, m_ill = 1'b0;
  logic [31:0] m_res = 32'h0, m_pend = 32'h0;
  logic        exp_ready;

  always_comb w_ref = ref_alu(req_opcode, req_val1, req_val2);
  // Busy while a multiply result is due at a later edge than the one just taken.
  always_comb exp_ready = !reset && !flush && (m_due < cyc);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0; m_res <= 32'h0; m_zero <= 1'b0; m_ovf <= 1'b0; m_ill <= 1'b0;
      m_due   <= -1;
    end else begin
      cyc <= cyc + 1;
      if (flush) begin
        m_valid <= 1'b0;
        m_due   <= -1;
      end else if (req_valid && (m_due < cyc)) begin
        if (req_opcode == 8'h02 && LAT > 1) begin
          m_due   <= cyc + LAT - 1;
          m_pend  <= w_ref.res;
          m_valid <= 1'b0;
        end else begin
          m_valid <= 1'b1;
          m_res   <= w_ref.res;
          m_zero  <= (w_ref.res == 32'h0);
          m_ovf   <= w_ref.ovf;
          m_ill   <= w_ref.ill;
        end
      end else if (m_due == cyc) begin
        m_valid <= 1'b1;
        m_res   <= m_pend;
        m_zero  <= (m_pend == 32'h0);
        m_ovf   <= 1'b0;
        m_ill   <= 1'b0;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("ready", req_ready, exp_ready);
    check("rsp_valid", rsp_valid, m_valid);
    check("rsp_result", rsp_result, m_res);
    check("rsp_zero", rsp_zero, m_zero);
    check("rsp_ovf", rsp_ovf, m_ovf);
    check("rsp_illegal", rsp_illegal, m_ill);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid  = v;
    req_opcode = op;
    req_val1   = a;
    req_val2   = b;
  endtask

  initial begin
    #3;
    check("reset valid", rsp_valid, 1'b0);
    check("reset result", rsp_result, 32'h0);
    check("reset ready", req_ready, 1'b0);
    step(); step();
    reset = 1'b0;
    #1 check("ready after release", req_ready, 1'b1);

    drive(1'b1, 8'h00, 32'h7FFF_FFFF, 32'h1);
    step();
    check("add valid", rsp_valid, 1'b1);
    check("add result", rsp_result, 32'h8000_0000);
    check("add ovf", rsp_ovf, 1'b1);
    check("add zero", rsp_zero, 1'b0);

    drive(1'b1, 8'h01, 32'd5, 32'd5); step();
    check("sub result", rsp_result, 32'h0);
    check("sub zero", rsp_zero, 1'b1);
    drive(1'b1, 8'h30, 32'd7, 32'd7); step();
    check("beq eq valid", rsp_valid, 1'b1);
    check("beq eq result", rsp_result, 32'd1);
    drive(1'b1, 8'h30, 32'd7, 32'd8); step();
    check("beq ne result", rsp_result, 32'd0);
    check("beq ne zero", rsp_zero, 1'b1);
    drive(1'b1, 8'h55, 32'd3, 32'd4); step();
    check("illegal flag", rsp_illegal, 1'b1);
    check("illegal result", rsp_result, 32'h0);
    drive(1'b0, 8'h00, 32'h0, 32'h0); step();

    // multiply with a request queued behind it
    drive(1'b1, 8'h02, 32'h1_0000, 32'h1_0000); step();
    drive(1'b1, 8'h00, 32'd3, 32'd4);
    check("mul busy 1", req_ready, 1'b0);
    step();
    check("mul busy 2", req_ready, 1'b0);
    check("mul not yet", rsp_valid, 1'b0);
    step();
    check("mul valid", rsp_valid, 1'b1);
    check("mul result", rsp_result, 32'h0);
    check("mul zero", rsp_zero, 1'b1);
    check("mul ready back", req_ready, 1'b1);
    step();
    check("queued add", rsp_result, 32'd7);
    drive(1'b0, 8'h00, 32'h0, 32'h0); step();

    // flush kills an in-flight multiply; a concurrent request is ignored
    drive(1'b1, 8'h02, 32'd6, 32'd7); step();
    flush = 1'b1;
    drive(1'b1, 8'h00, 32'd9, 32'd9);
    #1 check("ready during flush", req_ready, 1'b0);
    step();
    flush = 1'b0;
    drive(1'b0, 8'h00, 32'h0, 32'h0);
    #1 check("ready after flush", req_ready, 1'b1);
    repeat (4) step();
    flush = 1'b1;
    drive(1'b1, 8'h00, 32'd9, 32'd9); step();
    flush = 1'b0;
    drive(1'b0, 8'h00, 32'h0, 32'h0); step();
    drive(1'b1, 8'h00, 32'd1, 32'd2); step();
    check("add after flush", rsp_result, 32'd3);
    drive(1'b0, 8'h00, 32'h0, 32'h0); step();

    // asynchronous reset in the middle of a multiply
    drive(1'b1, 8'h02, 32'd6, 32'd7); step();
    drive(1'b0, 8'h00, 32'h0, 32'h0);
    #5 reset = 1'b1;
    #1;
    check("async rst result", rsp_result, 32'h0);
    check("async rst valid", rsp_valid, 1'b0);
    check("async rst ready", req_ready, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (5) step();
    check("no stale result", rsp_result, 32'h0);

    // MUL_LATENCY = 1: behaves like a single-cycle op
    l1_valid = 1'b1; l1_op = 8'h02; l1_a = 32'h1_0000; l1_b = 32'h1_0000; step();
    l1_op = 8'h00; l1_a = 32'd3; l1_b = 32'd4;
    check("l1 mul valid", l1_rvalid, 1'b1);
    check("l1 mul result", l1_res, 32'h0);
    check("l1 mul zero", l1_zero, 1'b1);
    check("l1 ready", l1_ready, 1'b1);
    step();
    l1_valid = 1'b0;
    check("l1 add result", l1_res, 32'd7);
    check("l1 flags", {l1_ovf, l1_ill}, 2'b00);
    step();
    check("l1 idle", l1_rvalid, 1'b0);

    // MUL_LATENCY = 15
    l15_valid = 1'b1; l15_op = 8'h02; l15_a = 32'h1_0000; l15_b = 32'h1_0000; step();
    l15_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      check("l15 busy ready", l15_ready, 1'b0);
      check("l15 busy valid", l15_rvalid, 1'b0);
      step();
    end
    check("l15 valid", l15_rvalid, 1'b1);
    check("l15 result", l15_res, 32'h0);
    check("l15 zero", l15_zero, 1'b1);
    check("l15 ready", l15_ready, 1'b1);
    check("l15 flags", {l15_ovf, l15_ill}, 2'b00);
    step();
    check("l15 pulse", l15_rvalid, 1'b0);

    // DATA_W = 16
    w16_valid = 1'b1; w16_op = 8'h02; w16_a = 16'hFFFF; w16_b = 16'hFFFF; step();
    w16_valid = 1'b0;
    check("w16 busy 1", w16_ready, 1'b0);
    step();
    check("w16 busy 2", w16_ready, 1'b0);
    step();
    check("w16 valid", w16_rvalid, 1'b1);
    check("w16 result", w16_res, 16'h0001);
    check("w16 zero", w16_zero, 1'b0);
    check("w16 flags", {w16_ovf, w16_ill}, 2'b00);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
